// File: rtl/rvga_types.sv
// Shared types for the RVGA memory subsystem: arbiter FSM states, grant side and
// the default error-read pattern.
package rvga_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/ddr_watchdog.sv
// Grant wait counter: cleared while no access is in flight, counts stalled grant
// cycles and flags the final allowed cycle.
module ddr_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is suppressed whenever the memory answers, so a real response wins.
  assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/ddr_arbiter.sv
// Two-master (instruction/data) arbiter onto a single DDR request port with
// round-robin tie-break, a one-cycle release gap and a response watchdog.
module ddr_arbiter
  import rvga_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iddr_addr,
  input  logic [31:0] iddr_wdata,
  input  logic        iddr_read,
  input  logic        iddr_write,
  output logic [31:0] iddr_rdata,
  output logic        iddr_resp,
  input  logic [31:0] dddr_addr,
  input  logic [31:0] dddr_wdata,
  input  logic        dddr_read,
  input  logic        dddr_write,
  output logic [31:0] dddr_rdata,
  output logic        dddr_resp,
  output logic [31:0] ddr_addr,
  output logic [31:0] ddr_wdata,
  output logic        ddr_read,
  output logic        ddr_write,
  input  logic [31:0] ddr_rdata,
  input  logic        ddr_resp,
  output logic        timeout_err
);

  arb_state_t state_q, state_d;
  side_t      last_q, last_d;
  logic       i_req, d_req, granted, expired;

  assign i_req   = iddr_read | iddr_write;
  assign d_req   = dddr_read | dddr_write;
  assign granted = (state_q == GNT_I) || (state_q == GNT_D);

  ddr_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!granted),
    .enable (granted && !ddr_resp),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    ddr_addr    = '0;
    ddr_wdata   = '0;
    ddr_read    = 1'b0;
    ddr_write   = 1'b0;
    iddr_resp   = 1'b0;
    dddr_resp   = 1'b0;
    iddr_rdata  = ddr_rdata;
    dddr_rdata  = ddr_rdata;
    timeout_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_q == SIDE_D)) begin
          state_d = GNT_I;
          last_d  = SIDE_I;
        end else if (d_req) begin
          state_d = GNT_D;
          last_d  = SIDE_D;
        end
      end
      GNT_I: begin
        ddr_addr  = iddr_addr;
        ddr_wdata = iddr_wdata;
        ddr_read  = iddr_read;
        ddr_write = iddr_write;
        if (!i_req) begin
          state_d = RELEASE;
        end else if (ddr_resp) begin
          iddr_resp = 1'b1;
          state_d   = RELEASE;
        end else if (expired) begin
          iddr_resp   = 1'b1;
          iddr_rdata  = ERR_DATA;
          timeout_err = 1'b1;
          state_d     = RELEASE;
        end
      end
      GNT_D: begin
        ddr_addr  = dddr_addr;
        ddr_wdata = dddr_wdata;
        ddr_read  = dddr_read;
        ddr_write = dddr_write;
        if (!d_req) begin
          state_d = RELEASE;
        end else if (ddr_resp) begin
          dddr_resp = 1'b1;
          state_d   = RELEASE;
        end else if (expired) begin
          dddr_resp   = 1'b1;
          dddr_rdata  = ERR_DATA;
          timeout_err = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to D so the first tie after reset goes to the instruction side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SIDE_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed self-checking bench for ddr_arbiter with TIMEOUT_CYCLES=16; inputs are
// driven 1ns after the rising edge and outputs checked 1ns later.
module tb_ddr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iddr_addr, iddr_wdata, iddr_rdata;
  logic        iddr_read, iddr_write, iddr_resp;
  logic [31:0] dddr_addr, dddr_wdata, dddr_rdata;
  logic        dddr_read, dddr_write, dddr_resp;
  logic [31:0] ddr_addr, ddr_wdata, ddr_rdata;
  logic        ddr_read, ddr_write, ddr_resp;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_arbiter #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iddr_addr  (iddr_addr),
    .iddr_wdata (iddr_wdata),
    .iddr_read  (iddr_read),
    .iddr_write (iddr_write),
    .iddr_rdata (iddr_rdata),
    .iddr_resp  (iddr_resp),
    .dddr_addr  (dddr_addr),
    .dddr_wdata (dddr_wdata),
    .dddr_read  (dddr_read),
    .dddr_write (dddr_write),
    .dddr_rdata (dddr_rdata),
    .dddr_resp  (dddr_resp),
    .ddr_addr   (ddr_addr),
    .ddr_wdata  (ddr_wdata),
    .ddr_read   (ddr_read),
    .ddr_write  (ddr_write),
    .ddr_rdata  (ddr_rdata),
    .ddr_resp   (ddr_resp),
    .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {iddr_addr, iddr_wdata, iddr_read, iddr_write} = '0;
    {dddr_addr, dddr_wdata, dddr_read, dddr_write} = '0;
    ddr_rdata = '0;
    ddr_resp  = 1'b0;
    #12;
    check_eq("rst_ddr_read", ddr_read, 1'b0);
    check_eq("rst_ddr_write", ddr_write, 1'b0);
    check_eq("rst_iresp", iddr_resp, 1'b0);
    check_eq("rst_dresp", dddr_resp, 1'b0);
    check_eq("rst_timeout", timeout_err, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Test 1: lone instruction read, memory answers in the 4th grant cycle
    cyc();
    iddr_read = 1'b1; iddr_addr = 32'h100;
    settle();
    check_eq("t1_idle_no_ddr_read", ddr_read, 1'b0);
    cyc();
    check_eq("t1_ddr_read", ddr_read, 1'b1);
    check_eq("t1_ddr_addr", ddr_addr, 32'h100);
    check_eq("t1_iresp_wait", iddr_resp, 1'b0);
    repeat (2) begin
      cyc();
      check_eq("t1_iresp_wait", iddr_resp, 1'b0);
      check_eq("t1_dresp_quiet", dddr_resp, 1'b0);
    end
    cyc();
    ddr_resp = 1'b1; ddr_rdata = 32'hCAFE0100;
    settle();
    check_eq("t1_iresp", iddr_resp, 1'b1);
    check_eq("t1_irdata", iddr_rdata, 32'hCAFE0100);
    check_eq("t1_dresp_quiet", dddr_resp, 1'b0);
    cyc();
    iddr_read = 1'b0; ddr_resp = 1'b0;
    settle();
    check_eq("t1_release_idle_port", ddr_read, 1'b0);
    check_eq("t1_release_no_iresp", iddr_resp, 1'b0);
    cyc();

    // Test 2: simultaneous I read and D write after reset; I first, then D
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    iddr_read = 1'b1; iddr_addr = 32'h300;
    dddr_write = 1'b1; dddr_addr = 32'h200; dddr_wdata = 32'h12345678;
    settle();
    cyc();
    check_eq("t2_i_first_read", ddr_read, 1'b1);
    check_eq("t2_i_first_write", ddr_write, 1'b0);
    check_eq("t2_i_first_addr", ddr_addr, 32'h300);
    ddr_resp = 1'b1;
    settle();
    check_eq("t2_iresp", iddr_resp, 1'b1);
    check_eq("t2_no_dresp", dddr_resp, 1'b0);
    cyc();
    iddr_read = 1'b0; ddr_resp = 1'b0;
    settle();
    check_eq("t2_release_write", ddr_write, 1'b0);
    check_eq("t2_release_read", ddr_read, 1'b0);
    cyc();
    check_eq("t2_idle_write", ddr_write, 1'b0);
    cyc();
    check_eq("t2_d_write", ddr_write, 1'b1);
    check_eq("t2_d_read", ddr_read, 1'b0);
    check_eq("t2_d_addr", ddr_addr, 32'h200);
    check_eq("t2_d_wdata", ddr_wdata, 32'h12345678);
    ddr_resp = 1'b1;
    settle();
    check_eq("t2_dresp", dddr_resp, 1'b1);
    check_eq("t2_no_iresp", iddr_resp, 1'b0);
    cyc();
    dddr_write = 1'b0; ddr_resp = 1'b0;
    cyc();

    // Test 3: both sides hold requests for six accesses; grants alternate
    iddr_read = 1'b1; iddr_addr = 32'h1000;
    dddr_read = 1'b1; dddr_addr = 32'h2000;
    for (int a = 0; a < 6; a++) begin
      for (int w = 0; w < 6 && !ddr_read; w++) cyc();
      check_eq("t3_grant_seen", ddr_read, 1'b1);
      check_eq("t3_grant_order", ddr_addr, (a % 2 == 0) ? 32'h1000 : 32'h2000);
      ddr_resp = 1'b1;
      settle();
      check_eq("t3_resp", (a % 2 == 0) ? iddr_resp : dddr_resp, 1'b1);
      cyc();
      ddr_resp = 1'b0;
    end
    iddr_read = 1'b0; dddr_read = 1'b0;
    cyc();

    // Test 4: D read never answered; forced completion on the 16th grant cycle
    dddr_read = 1'b1; dddr_addr = 32'h400; ddr_rdata = 32'h11111111;
    cyc();
    for (int k = 1; k < 16; k++) begin
      check_eq("t4_early_dresp", dddr_resp, 1'b0);
      check_eq("t4_early_timeout", timeout_err, 1'b0);
      cyc();
    end
    check_eq("t4_dresp", dddr_resp, 1'b1);
    check_eq("t4_drdata_err", dddr_rdata, 32'hDEADBEEF);
    check_eq("t4_timeout_pulse", timeout_err, 1'b1);
    check_eq("t4_no_iresp", iddr_resp, 1'b0);
    check_eq("t4_irdata_passthru", iddr_rdata, 32'h11111111);
    cyc();
    dddr_read = 1'b0;
    settle();
    check_eq("t4_timeout_once", timeout_err, 1'b0);
    check_eq("t4_dresp_once", dddr_resp, 1'b0);
    cyc();

    // Test 5: reset mid GNT_D abandons the access; first tie then grants I
    dddr_read = 1'b1; dddr_addr = 32'h500;
    cyc();
    check_eq("t5_gnt_d", ddr_read, 1'b1);
    rst_n = 1'b0; ddr_resp = 1'b1;
    settle();
    check_eq("t5_rst_read", ddr_read, 1'b0);
    check_eq("t5_rst_write", ddr_write, 1'b0);
    check_eq("t5_rst_dresp", dddr_resp, 1'b0);
    check_eq("t5_rst_iresp", iddr_resp, 1'b0);
    rst_n = 1'b1; ddr_resp = 1'b0;
    iddr_read = 1'b1; iddr_addr = 32'h600;
    settle();
    cyc();
    check_eq("t5_tie_read", ddr_read, 1'b1);
    check_eq("t5_tie_to_i", ddr_addr, 32'h600);
    ddr_resp = 1'b1;
    settle();
    check_eq("t5_iresp", iddr_resp, 1'b1);
    cyc();
    iddr_read = 1'b0; dddr_read = 1'b0; ddr_resp = 1'b0;
    cyc();

    // Test 6: I drops its read mid-grant; pending D is served next
    iddr_read = 1'b1; iddr_addr = 32'h700;
    cyc();
    dddr_read = 1'b1; dddr_addr = 32'h800;
    cyc();
    cyc();
    iddr_read = 1'b0;
    settle();
    check_eq("t6_drop_no_iresp", iddr_resp, 1'b0);
    cyc();
    check_eq("t6_release_port", ddr_read, 1'b0);
    check_eq("t6_release_no_iresp", iddr_resp, 1'b0);
    cyc();
    check_eq("t6_idle_port", ddr_read, 1'b0);
    cyc();
    check_eq("t6_d_read", ddr_read, 1'b1);
    check_eq("t6_d_addr", ddr_addr, 32'h800);
    ddr_resp = 1'b1;
    settle();
    check_eq("t6_dresp", dddr_resp, 1'b1);
    check_eq("t6_no_iresp", iddr_resp, 1'b0);
    cyc();
    dddr_read = 1'b0; ddr_resp = 1'b0;
    cyc();

    // Test 7: ddr_resp ignored in IDLE; response on the timeout cycle wins
    ddr_resp = 1'b1;
    settle();
    check_eq("t7_idle_iresp", iddr_resp, 1'b0);
    check_eq("t7_idle_dresp", dddr_resp, 1'b0);
    ddr_resp = 1'b0;
    dddr_read = 1'b1; dddr_addr = 32'h900; ddr_rdata = 32'h22222222;
    cyc();
    repeat (15) cyc();
    ddr_resp = 1'b1;
    settle();
    check_eq("t7_dresp", dddr_resp, 1'b1);
    check_eq("t7_real_data", dddr_rdata, 32'h22222222);
    check_eq("t7_no_timeout", timeout_err, 1'b0);
    cyc();
    dddr_read = 1'b0; ddr_resp = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
